// File: rtl/vga_fb_scan.sv
// 640x480@60 VGA scanner that reads a 256x256 RGB444 framebuffer centred in the active area.
// Optional build macro VGA_SCAN_GRID_EN overlays a white axis cross at image x==128 / y==128.
module vga_fb_scan #(
  parameter logic [9:0] H_ACTIVE     = 10'd640,
  parameter logic [9:0] H_SYNC_START = 10'd656,
  parameter logic [9:0] H_SYNC_END   = 10'd752,
  parameter logic [9:0] H_TOTAL      = 10'd800,
  parameter logic [9:0] V_ACTIVE     = 10'd480,
  parameter logic [9:0] V_SYNC_START = 10'd490,
  parameter logic [9:0] V_SYNC_END   = 10'd492,
  parameter logic [9:0] V_TOTAL      = 10'd525,
  parameter logic [9:0] WIN_X0       = 10'd192,
  parameter logic [9:0] WIN_Y0       = 10'd112
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        plot_done,
  output logic [15:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic [9:0]  CounterX,
  output logic [9:0]  CounterY,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] color,
  output logic        frame_done
);

  localparam logic [9:0] H_LAST = H_TOTAL - 10'd1;
  localparam logic [9:0] V_LAST = V_TOTAL - 10'd1;
  localparam logic [9:0] WIN_X1 = WIN_X0 + 10'd256;
  localparam logic [9:0] WIN_Y1 = WIN_Y0 + 10'd256;

  logic [9:0]  x_nxt;
  logic [9:0]  y_nxt;
  logic        at_end;
  logic        plot_latch;
  logic        showing;
  logic        hs1;
  logic        vs1;
  logic        de1;
  logic        win1;
  logic        show1;
  logic [11:0] pix;
`ifdef VGA_SCAN_GRID_EN
  logic        grid1;
`endif

  // Window is clipped to the active area so rd_data is never shown in blanking.
  function automatic logic in_win(input logic [9:0] x, input logic [9:0] y);
    return (x < H_ACTIVE) && (y < V_ACTIVE) &&
           (x >= WIN_X0) && (x < WIN_X1) && (y >= WIN_Y0) && (y < WIN_Y1);
  endfunction

  always_comb begin
    at_end = (CounterX == H_LAST) && (CounterY == V_LAST);
    x_nxt  = CounterX + 10'd1;
    y_nxt  = CounterY;
    if (CounterX == H_LAST) begin
      x_nxt = 10'd0;
      if (CounterY == V_LAST) begin
        y_nxt = 10'd0;
      end else begin
        y_nxt = CounterY + 10'd1;
      end
    end else begin
      x_nxt = CounterX + 10'd1;
    end
  end

  // rd_addr and frame_done are built from the next counter values so they line up with CounterX/Y.
  always_ff @(posedge clk) begin
    if (reset) begin
      CounterX   <= 10'd0;
      CounterY   <= 10'd0;
      rd_addr    <= 16'h0000;
      frame_done <= 1'b0;
      plot_latch <= 1'b0;
      showing    <= 1'b0;
    end else begin
      CounterX   <= x_nxt;
      CounterY   <= y_nxt;
      rd_addr    <= in_win(x_nxt, y_nxt) ? {8'(y_nxt - WIN_Y0), 8'(x_nxt - WIN_X0)} : 16'h0000;
      frame_done <= (x_nxt == H_LAST) && (y_nxt == V_LAST);
      plot_latch <= plot_latch | plot_done;
      if (at_end) begin
        showing <= enable & (showing | plot_latch);
      end else begin
        showing <= showing;
      end
    end
  end

  // Stage 1: timing flags travel alongside the RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      de1   <= 1'b0;
      win1  <= 1'b0;
      show1 <= 1'b0;
`ifdef VGA_SCAN_GRID_EN
      grid1 <= 1'b0;
`endif
    end else begin
      hs1   <= !((CounterX >= H_SYNC_START) && (CounterX < H_SYNC_END));
      vs1   <= !((CounterY >= V_SYNC_START) && (CounterY < V_SYNC_END));
      de1   <= (CounterX < H_ACTIVE) && (CounterY < V_ACTIVE);
      win1  <= in_win(CounterX, CounterY);
      show1 <= showing;
`ifdef VGA_SCAN_GRID_EN
      grid1 <= (8'(CounterX - WIN_X0) == 8'd128) || (8'(CounterY - WIN_Y0) == 8'd128);
`endif
    end
  end

  always_comb begin
    pix = 12'h000;
    if (show1 && win1) begin
`ifdef VGA_SCAN_GRID_EN
      pix = grid1 ? 12'hFFF : rd_data;
`else
      pix = rd_data;
`endif
    end else if (show1 && de1) begin
      pix = 12'h00F;
    end else begin
      pix = 12'h000;
    end
  end

  // Stage 2: registered video outputs, two cycles behind the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      color <= 12'h000;
    end else begin
      hsync <= hs1;
      vsync <= vs1;
      de    <= de1;
      color <= pix;
    end
  end

endmodule
